// File: rtl/brlshft_arb.sv
// Round-robin arbiter that time-shares one 4-bit combinational barrel shifter
// among NREQ requesters and holds each tagged result behind a valid/ready handshake.
module brlshft_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_lr,
  input  logic [NREQ-1:0]     req_rot,
  input  logic [2*NREQ-1:0]   req_sv,
  input  logic [4*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                sh_l_r,
  output logic                sh_rot,
  output logic                sh_sv0,
  output logic                sh_sv1,
  output logic [3:0]          sh_in,
  input  logic [3:0]          sh_out,
  output logic                res_valid,
  output logic [3:0]          res_data,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready,
  output logic [15:0]         op_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic           any_req;
  logic           acc;
  logic           done;

  assign res_valid = (state == FULL);
  assign done      = res_valid && res_ready;

  // Scan offsets from the highest down so the requester closest to the
  // pointer (offset 0) is the last to overwrite the winner and so has priority.
  always_comb begin
    logic [IDW-1:0] idx;
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    any_req = |req;
    winner  = ptr;
    idx     = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDW'(k);
      if (req[idx]) winner = idx;
    end
  end

  // A held result blocks new work unless the consumer drains it this cycle;
  // reset suppresses grants so nothing is lost to the discarded cycle.
  assign acc = any_req && (state == EMPTY || res_ready) && !rst;

  always_comb begin
    gnt    = '0;
    sh_l_r = 1'b0;
    sh_rot = 1'b0;
    sh_sv0 = 1'b0;
    sh_sv1 = 1'b0;
    sh_in  = 4'b0000;
    if (acc) begin
      gnt[winner] = 1'b1;
      sh_l_r      = req_lr[winner];
      sh_rot      = req_rot[winner];
      sh_sv0      = req_sv[{winner, 1'b0}];
      sh_sv1      = req_sv[{winner, 1'b1}];
      sh_in       = req_data[{winner, 2'b00} +: 4];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      res_data <= 4'b0000;
      res_id   <= '0;
      op_cnt   <= 16'h0000;
    end else begin
      if (done) op_cnt <= op_cnt + 16'd1;
      if (acc) begin
        // Back-to-back: a completion and a new capture share this edge.
        res_data <= sh_out;
        res_id   <= winner;
        ptr      <= winner + 1'b1;
        state    <= FULL;
      end else if (done) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_brlshft_arb.sv
// Directed table-driven bench for brlshft_arb with a behavioural shifter model
// standing in for the shared brlshft instance.
module tb_brlshft_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_lr, req_rot;
  logic [7:0]  req_sv;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        sh_l_r, sh_rot, sh_sv0, sh_sv1;
  logic [3:0]  sh_in, sh_out;
  logic        res_valid;
  logic [3:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [15:0] op_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  brlshft_arb #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lr(req_lr), .req_rot(req_rot),
    .req_sv(req_sv), .req_data(req_data), .gnt(gnt), .sh_l_r(sh_l_r),
    .sh_rot(sh_rot), .sh_sv0(sh_sv0), .sh_sv1(sh_sv1), .sh_in(sh_in),
    .sh_out(sh_out), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready), .op_cnt(op_cnt)
  );

  function automatic logic [3:0] shf(input logic lr, input logic rot,
                                     input logic [1:0] n, input logic [3:0] d);
    int s;
    s = int'(n);
    if (lr) return rot ? ((d << s) | (d >> (4 - s))) : (d << s);
    else    return rot ? ((d >> s) | (d << (4 - s))) : (d >> s);
  endfunction

  always_comb sh_out = shf(sh_l_r, sh_rot, {sh_sv1, sh_sv0}, sh_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lr;
    logic [3:0]  rot;
    logic [7:0]  sv;
    logic [15:0] data;
    logic        ready;
    logic [3:0]  gnt;
    logic        v;
    logic [3:0]  d;
    logic [1:0]  id;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    logic [7:0] exp_sh;
    //            rst req      lr       rot      sv           data      rdy gnt      v  d        id     cnt
    tbl[0]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 8'b00000001, 16'h000D, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0, 16'd0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd0, 16'd1};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 8'b00010000, 16'h0D00, 1'b1, 4'b0100, 1'b1, 4'hE, 2'd2, 16'd1};
    tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 8'b00110000, 16'h0D00, 1'b1, 4'b0100, 1'b1, 4'hE, 2'd2, 16'd2};
    tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 8'b00110000, 16'h0D00, 1'b1, 4'b0100, 1'b1, 4'h8, 2'd2, 16'd3};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h8, 2'd2, 16'd4};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0, 16'd0};
    tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0, 16'd0};
    tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1, 16'd1};
    tbl[9]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b1, 4'b0100, 1'b1, 4'h6, 2'd2, 16'd2};
    tbl[10] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3, 16'd3};
    tbl[11] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0, 16'd4};
    for (int i = 12; i < 17; i++)
      tbl[i] = '{1'b0, 4'b0010, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd0, 16'd4};
    tbl[17] = '{1'b0, 4'b0010, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1, 16'd5};
    tbl[18] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 16'd0};
    tbl[19] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'b00000000, 16'h9653, 1'b0, 4'b0001, 1'b1, 4'h3, 2'd0, 16'd0};
    tbl[20] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd0, 16'd0};
    tbl[21] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'b00000000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd0, 16'd1};

    rst = 1'b1; req = '0; req_lr = '0; req_rot = '0; req_sv = '0; req_data = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", 32'(res_valid), 32'd0);
    check("reset data", 32'(res_data), 32'd0);
    check("reset id", 32'(res_id), 32'd0);
    check("reset cnt", 32'(op_cnt), 32'd0);
    check("reset gnt", 32'(gnt), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; req_lr = tbl[i].lr; req_rot = tbl[i].rot;
      req_sv = tbl[i].sv; req_data = tbl[i].data; res_ready = tbl[i].ready;
      #1;
      exp_sh = 8'h00;
      for (int w = 0; w < 4; w++)
        if (tbl[i].gnt[w])
          exp_sh = {tbl[i].lr[w], tbl[i].rot[w], tbl[i].sv[2*w+1], tbl[i].sv[2*w],
                    tbl[i].data[4*w +: 4]};
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("v%0d sh", i), 32'({sh_l_r, sh_rot, sh_sv1, sh_sv0, sh_in}), 32'(exp_sh));
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), 32'(res_valid), 32'(tbl[i].v));
      check($sformatf("v%0d data", i), 32'(res_data), 32'(tbl[i].d));
      check($sformatf("v%0d id", i), 32'(res_id), 32'(tbl[i].id));
      check($sformatf("v%0d cnt", i), 32'(op_cnt), 32'(tbl[i].cnt));
    end

    // Counter wrap: one accept per cycle, completions start one edge later.
    @(negedge clk);
    rst = 1'b1; req = '0; res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b0001; req_lr = 4'b0001; req_rot = '0; req_sv = '0; req_data = 16'h0007;
    @(posedge clk);
    #1;
    check("wrap first valid", 32'(res_valid), 32'd1);
    check("wrap first cnt", 32'(op_cnt), 32'd0);
    repeat (65535) @(posedge clk);
    #1;
    check("wrap ffff", 32'(op_cnt), 32'h0000FFFF);
    @(negedge clk);
    req = '0;
    @(posedge clk);
    #1;
    check("wrap zero", 32'(op_cnt), 32'd0);
    check("wrap empty", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
